// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All line-facing outputs are registered from the next-state decode so they change on the clock edge.
module uart_tx_frame_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits_2,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [1:0]            bit_select
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;

  logic                  serial_q, serial_d;
  logic [1:0]            sel_q, sel_d;
  logic                  done_q, done_d;
  logic                  busy_q, ready_q;

  logic                  accept;
  logic                  bit_end;

  // ready_q mirrors (state_q == S_IDLE), so accept never fires mid-frame.
  assign accept  = tx_valid & ready_q;
  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          cnt_d     = '0;
          idx_d     = '0;
          shreg_d   = tx_data;
          par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_bit_d = (parity_mode == 2'b10) ? ~^tx_data : ^tx_data;
          stop2_d   = stop_bits_2;
        end
      end
      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              idx_d   = '0;
            end
            S_DATA: begin
              shreg_d = shreg_q >> 1;
              if (idx_q == IDX_LAST) begin
                state_d = par_en_q ? S_PARITY : S_STOP;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              idx_d   = '0;
            end
            S_STOP: begin
              if (stop2_q && (idx_q == '0)) begin
                idx_d = IDX_ONE;
              end else begin
                state_d = S_IDLE;
                idx_d   = '0;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    case (state_d)
      S_START:  begin serial_d = 1'b0;       sel_d = SEL_START;  end
      S_DATA:   begin serial_d = shreg_d[0]; sel_d = SEL_DATA;   end
      S_PARITY: begin serial_d = par_bit_d;  sel_d = SEL_PARITY; end
      default:  begin serial_d = 1'b1;       sel_d = SEL_STOP;   end
    endcase

    // Pulse lands in the last cycle of the final stop bit.
    done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX) &&
             (!stop2_d || (idx_d == IDX_ONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      serial_q  <= 1'b1;
      sel_q     <= SEL_STOP;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      serial_q  <= serial_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      busy_q    <= (state_d != S_IDLE);
      ready_q   <= (state_d == S_IDLE);
    end
  end

  assign tx_serial  = serial_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_ready   = ready_q;
  assign bit_select = sel_q;

endmodule
